// File: rtl/alsu_cmd_issuer_if.sv
// Command/response handshake bundle between a control master and alsu_cmd_issuer.
interface alsu_cmd_issuer_if #(parameter int TAG_W = 4);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [16+TAG_W:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [5:0]        rsp_out;
    logic              rsp_err;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (output cmd_valid, cmd_data, rsp_ready,
                    input  cmd_ready, rsp_valid, rsp_out, rsp_err, rsp_tag);
    modport slave  (input  cmd_valid, cmd_data, rsp_ready,
                    output cmd_ready, rsp_valid, rsp_out, rsp_err, rsp_tag);
endinterface

// File: rtl/alsu_cmd_issuer.sv
// Queues packed ALSU commands, drives the ALSU pins, and returns each captured
// result as a tagged response; issue is credit-limited by free response space.
module alsu_cmd_issuer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 8,
    parameter int TAG_W     = 4,
    parameter int ALSU_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    alsu_cmd_issuer_if.slave bus,
    output logic [2:0]       alsu_A,
    output logic [2:0]       alsu_B,
    output logic [2:0]       alsu_opcode,
    output logic             alsu_cin,
    output logic             alsu_serial_in,
    output logic             alsu_red_op_A,
    output logic             alsu_red_op_B,
    output logic             alsu_bypass_A,
    output logic             alsu_bypass_B,
    output logic             alsu_direction,
    input  logic [5:0]       alsu_out
);
    localparam int CW     = $clog2(CMD_DEPTH);
    localparam int RW     = $clog2(RSP_DEPTH);
    localparam int STAGES = ALSU_LAT;

    typedef struct packed {
        logic       dir, byp_b, byp_a, red_b, red_a, serial_in, cin;
        logic [2:0] b, a, opcode;
    } op_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        op_t              op;
    } cmd_t;

    typedef struct packed {
        logic             err;
        logic [TAG_W-1:0] tag;
    } meta_t;

    typedef struct packed {
        logic [5:0]       out;
        logic             err;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    function automatic logic cmd_invalid(op_t c);
        return (c.opcode > 3'd5) || ((c.red_a | c.red_b) && (c.opcode > 3'd1));
    endfunction

    // Command FIFO; the top cmd_data bit is a spare and is ignored.
    cmd_t          cmd_mem [CMD_DEPTH];
    logic [CW-1:0] cmd_wp, cmd_rp;
    logic [CW:0]   cmd_cnt;
    cmd_t          cmd_in, cmd_head;
    logic          cmd_push, issue;
    logic          unused_rsvd;

    assign cmd_in        = cmd_t'(bus.cmd_data[15+TAG_W:0]);
    assign unused_rsvd   = bus.cmd_data[16+TAG_W];
    assign cmd_head      = cmd_mem[cmd_rp];
    assign bus.cmd_ready = (cmd_cnt != (CW+1)'(CMD_DEPTH));
    assign cmd_push      = bus.cmd_valid & bus.cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + CW'(1);
            if (issue)    cmd_rp <= cmd_rp + CW'(1);
            cmd_cnt <= cmd_cnt + (CW+1)'(cmd_push) - (CW+1)'(issue);
        end
    end

    always_ff @(posedge clk)
        if (cmd_push) cmd_mem[cmd_wp] <= cmd_in;

    // Credit: every valid pipeline stage already owns a response slot.
    logic [STAGES:0] vld_pipe;
    meta_t           meta_pipe [STAGES+1];
    logic [RW+1:0]   inflight;
    logic [RW:0]     rsp_cnt;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= STAGES; i++)
            inflight = inflight + (RW+2)'(vld_pipe[i]);
    end

    assign issue = (cmd_cnt != '0) &&
                   ((inflight + (RW+2)'(rsp_cnt)) < (RW+2)'(RSP_DEPTH));

    // Idle cycles load all-zero pins, i.e. OR of zero operands.
    op_t pin_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_q    <= '0;
            vld_pipe <= '0;
        end else begin
            pin_q    <= issue ? cmd_head.op : '0;
            vld_pipe <= {vld_pipe[STAGES-1:0], issue};
        end
    end

    always_ff @(posedge clk) begin
        meta_pipe[0] <= '{err: cmd_invalid(cmd_head.op), tag: cmd_head.tag};
        for (int i = 1; i <= STAGES; i++)
            meta_pipe[i] <= meta_pipe[i-1];
    end

    assign alsu_A         = pin_q.a;
    assign alsu_B         = pin_q.b;
    assign alsu_opcode    = pin_q.opcode;
    assign alsu_cin       = pin_q.cin;
    assign alsu_serial_in = pin_q.serial_in;
    assign alsu_red_op_A  = pin_q.red_a;
    assign alsu_red_op_B  = pin_q.red_b;
    assign alsu_bypass_A  = pin_q.byp_a;
    assign alsu_bypass_B  = pin_q.byp_b;
    assign alsu_direction = pin_q.dir;

    // Response FIFO
    rsp_t          rsp_mem [RSP_DEPTH];
    logic [RW-1:0] rsp_wp, rsp_rp;
    logic          cap, rsp_pop;
    rsp_t          rsp_head;

    assign cap           = vld_pipe[STAGES];
    assign bus.rsp_valid = (rsp_cnt != '0);
    assign rsp_pop       = bus.rsp_valid & bus.rsp_ready;
    assign rsp_head      = bus.rsp_valid ? rsp_mem[rsp_rp] : '0;
    assign bus.rsp_out   = rsp_head.out;
    assign bus.rsp_err   = rsp_head.err;
    assign bus.rsp_tag   = rsp_head.tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            rsp_cnt <= '0;
        end else begin
            if (cap)     rsp_wp <= rsp_wp + RW'(1);
            if (rsp_pop) rsp_rp <= rsp_rp + RW'(1);
            rsp_cnt <= rsp_cnt + (RW+1)'(cap) - (RW+1)'(rsp_pop);
        end
    end

    always_ff @(posedge clk)
        if (cap)
            rsp_mem[rsp_wp] <= '{out: alsu_out, err: meta_pipe[STAGES].err,
                                 tag: meta_pipe[STAGES].tag};
endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Bench for alsu_cmd_issuer: behavioural ALSU stand-in plus a queue-based
// reference of expected responses computed from each accepted command.
module tb_alsu_cmd_issuer;
    localparam int TAG_W = 4, CMD_DEPTH = 4, RSP_DEPTH = 8, ALSU_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alsu_cmd_issuer_if #(.TAG_W(TAG_W)) bus();

    logic [2:0] alsu_A, alsu_B, alsu_opcode;
    logic       alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
    logic       alsu_bypass_A, alsu_bypass_B, alsu_direction;
    logic [5:0] alsu_out;

    alsu_cmd_issuer #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W),
                      .ALSU_LAT(ALSU_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_direction(alsu_direction), .alsu_out(alsu_out));

    typedef struct packed {
        logic       dir, bb, ba, rb, ra, si, cin;
        logic [2:0] b, a, op;
    } pins_t;

    typedef struct {
        logic [5:0] out;
        logic       err;
        logic [3:0] tag;
    } exp_t;

    int   checks = 0, errors = 0;
    int   n_rsp = 0;
    bit   done = 0;
    exp_t q[$];
    exp_t seen[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic invalid(pins_t p);
        return (p.op > 3'd5) || ((p.ra | p.rb) && (p.op > 3'd1));
    endfunction

    // ALSU behaviour: OR/XOR with optional reductions, ADD, MULT, SHIFT/ROTATE of previous out.
    function automatic logic [5:0] alsu_f(pins_t p, logic [5:0] prev);
        if (invalid(p)) return 6'd0;
        if (p.ba) return {3'd0, p.a};
        if (p.bb) return {3'd0, p.b};
        case (p.op)
            3'd0:    return p.ra ? {5'd0, |p.a} : p.rb ? {5'd0, |p.b} : {3'd0, p.a | p.b};
            3'd1:    return p.ra ? {5'd0, ^p.a} : p.rb ? {5'd0, ^p.b} : {3'd0, p.a ^ p.b};
            3'd2:    return 6'(p.a) + 6'(p.b) + 6'(p.cin);
            3'd3:    return 6'(p.a) * 6'(p.b);
            3'd4:    return p.dir ? {prev[4:0], p.si} : {p.si, prev[5:1]};
            default: return p.dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
        endcase
    endfunction

    // ALSU stand-in: input register then output register.
    pins_t      pins, in_q;
    logic [5:0] out_q;
    assign pins = {alsu_direction, alsu_bypass_B, alsu_bypass_A, alsu_red_op_B, alsu_red_op_A,
                   alsu_serial_in, alsu_cin, alsu_B, alsu_A, alsu_opcode};
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q  <= '0;
            out_q <= '0;
        end else begin
            in_q  <= pins;
            out_q <= alsu_f(in_q, out_q);
        end
    end
    assign alsu_out = out_q;

    function automatic logic [20:0] mk(logic [3:0] tag, logic dir, logic bb, logic ba, logic rb,
                                       logic ra, logic si, logic cin, logic [2:0] b,
                                       logic [2:0] a, logic [2:0] op);
        return {1'b0, tag, dir, bb, ba, rb, ra, si, cin, b, a, op};
    endfunction

    function automatic logic [20:0] rand_cmd();
        logic [2:0]  op;
        logic [15:0] r;
        logic [20:0] d;
        r = 16'($urandom);
        case ($urandom_range(0, 5))
            0: op = 3'd0;  1: op = 3'd1;  2: op = 3'd2;
            3: op = 3'd3;  4: op = 3'd6;  default: op = 3'd7;
        endcase
        d = mk(4'($urandom), r[0], r[1] & r[2] & r[3], r[4] & r[5] & r[6], r[7] & r[8],
               r[9] & r[10], r[11], r[12], 3'($urandom), 3'($urandom), op);
        d[20] = r[13];
        return d;
    endfunction

    // Reference: expected responses queued in acceptance order; reset discards them.
    initial begin
        exp_t       e;
        pins_t      p;
        logic [5:0] last_exp;
        last_exp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                last_exp = '0;
            end else begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    p     = pins_t'(bus.cmd_data[15:0]);
                    e.out = alsu_f(p, last_exp);
                    e.err = invalid(p);
                    e.tag = bus.cmd_data[19:16];
                    last_exp = e.out;
                    q.push_back(e);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    n_rsp++;
                    e.out = bus.rsp_out;
                    e.err = bus.rsp_err;
                    e.tag = bus.rsp_tag;
                    seen.push_back(e);
                    chk("rsp_expected", q.size() != 0, 1'b1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("rsp_out", bus.rsp_out, e.out);
                        chk("rsp_err", bus.rsp_err, e.err);
                        chk("rsp_tag", bus.rsp_tag, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic send(input logic [20:0] d);
        int   n = 0;
        logic acc = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", acc, 1'b1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((q.size() != 0 || bus.rsp_valid) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_rsp_valid", bus.rsp_valid, 1'b0);
    endtask

    initial begin
        int base, nbase;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_fields", {bus.rsp_out, bus.rsp_err, bus.rsp_tag}, '0);
        chk("rst_pins", pins, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: ADD 3+2+1, pin and response latency
        send(mk(4'd5, 0, 0, 0, 0, 0, 0, 1, 3'd2, 3'd3, 3'd2));
        @(posedge clk); #1;
        chk("t1_pins", pins, {7'b0000001, 3'd2, 3'd3, 3'd2});
        repeat (2) begin @(posedge clk); #1; end
        chk("t1_rsp_not_yet", bus.rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk("t1_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t1_rsp", {bus.rsp_out, bus.rsp_err, bus.rsp_tag}, {6'd6, 1'b0, 4'd5});
        drain(50);

        // 2: invalid opcode
        base = seen.size();
        send(mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 3'd1, 3'd1, 3'd6));
        drain(50);
        chk("t2_count", seen.size() - base, 1);
        if (seen.size() > base)
            chk("t2_rsp", {seen[base].out, seen[base].err, seen[base].tag}, {6'd0, 1'b1, 4'd2});

        // 3: MULT then OR-reduce, back to back
        base = seen.size();
        send(mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 3'd2, 3'd3, 3'd3));
        send(mk(4'd4, 0, 0, 0, 0, 1, 0, 0, 3'd0, 3'd3, 3'd0));
        drain(50);
        chk("t3_count", seen.size() - base, 2);
        if (seen.size() > base + 1) begin
            chk("t3_mult", {seen[base].out, seen[base].err}, {6'd6, 1'b0});
            chk("t3_or_red", {seen[base+1].out, seen[base+1].err}, {6'd1, 1'b0});
        end

        // 4: bypass, shift, rotate chain
        base = seen.size();
        send(mk(4'd7, 0, 0, 1, 0, 0, 0, 0, 3'd0, 3'd3, 3'd0));
        send(mk(4'd8, 1, 0, 0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd4));
        send(mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd5));
        drain(50);
        chk("t4_count", seen.size() - base, 3);
        if (seen.size() > base + 2) begin
            chk("t4_bypass", seen[base].out, 6'b000011);
            chk("t4_shift", seen[base+1].out, 6'b000111);
            chk("t4_rotate", seen[base+2].out, 6'b100011);
        end

        // 5: back-pressure; credits stop issue with RSP_DEPTH buffered
        nbase = n_rsp;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 12; i++)
            send(mk(4'(i), 0, 0, 0, 0, 0, 0, 0, 3'd1, 3'(i % 7 + 1), 3'd2));
        repeat (6) begin @(posedge clk); #1; end
        chk("t5_cmd_full", bus.cmd_ready, 1'b0);
        chk("t5_rsp_held", bus.rsp_valid, 1'b1);
        chk("t5_pins_idle", pins, '0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("t5_one_credit", bus.cmd_ready, 1'b1);
        chk("t5_one_popped", n_rsp - nbase, 1);
        bus.rsp_ready = 1'b1;
        for (int i = 12; i < 16; i++)
            send(mk(4'(i), 0, 0, 0, 0, 0, 0, 0, 3'd1, 3'(i % 7 + 1), 3'd2));
        drain(200);
        chk("t5_total", n_rsp - nbase, 16);

        // 6: reset with commands in flight
        send(rand_cmd());
        send(rand_cmd());
        send(rand_cmd());
        @(posedge clk); #1;
        nbase = n_rsp;
        rst = 1'b1;
        #1;
        chk("t6_rsp_valid", bus.rsp_valid, 1'b0);
        chk("t6_cmd_ready", bus.cmd_ready, 1'b1);
        chk("t6_pins_idle", pins, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("t6_no_stale", n_rsp - nbase, 0);

        // Random traffic with random back-pressure
        nbase = n_rsp;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(rand_cmd());
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.rsp_ready = ($urandom_range(0, 3) != 0);
                end
                bus.rsp_ready = 1'b1;
            end
        join
        drain(500);
        chk("rand_total", n_rsp - nbase, 80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
